// File: rtl/rv_pkg.sv
// Shared definitions for the multicycle RV32-subset core: opcodes, controller states,
// ALU constants and instruction field slicers.
package rv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_SRX   = 3'b101;
    localparam logic [3:0] ALU_ADD  = 4'b0000;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    function automatic logic [6:0] f_opcode(input logic [31:0] ir);
        return ir[6:0];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[11:7];
    endfunction

    function automatic logic [2:0] f_func3(input logic [31:0] ir);
        return ir[14:12];
    endfunction

    function automatic logic [4:0] f_rs1(input logic [31:0] ir);
        return ir[19:15];
    endfunction

    function automatic logic [4:0] f_rs2(input logic [31:0] ir);
        return ir[24:20];
    endfunction

    function automatic logic f_func7b5(input logic [31:0] ir);
        return ir[30];
    endfunction

endpackage

// File: rtl/rv_alu.sv
// ALU: opcode is {func3, alt}; alt selects SUB over ADD and SRA over SRL.
module rv_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_y
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [SHW-1:0] w_sh;

    assign w_sh = i_b[SHW-1:0];

    always_comb begin
        o_y = '0;
        unique case (i_op[3:1])
            3'b000:  o_y = i_op[0] ? (i_a - i_b) : (i_a + i_b);
            3'b001:  o_y = i_a << w_sh;
            3'b010:  o_y[0] = $signed(i_a) < $signed(i_b);
            3'b011:  o_y[0] = i_a < i_b;
            3'b100:  o_y = i_a ^ i_b;
            3'b101:  o_y = i_op[0] ? $unsigned($signed(i_a) >>> w_sh) : (i_a >> w_sh);
            3'b110:  o_y = i_a | i_b;
            default: o_y = i_a & i_b;
        endcase
    end

endmodule

// File: rtl/rv_imm_gen.sv
// Immediate generator: sign-extends the I-type or S-type 12-bit immediate to XLEN.
module rv_imm_gen #(
    parameter int unsigned XLEN = 32
) (
    input  logic [11:0]     i_imm_hi,
    input  logic [4:0]      i_s_lo,
    input  logic            i_is_store,
    output logic [XLEN-1:0] o_imm
);

    logic [11:0] w_imm12;

    // I-type keeps instr[31:20]; S-type splices instr[31:25] with instr[11:7]
    assign w_imm12 = i_is_store ? {i_imm_hi[11:5], i_s_lo} : i_imm_hi;
    assign o_imm   = {{(XLEN-12){w_imm12[11]}}, w_imm12};

endmodule

// File: rtl/rv_rf.sv
// Register file: two combinational read ports, one synchronous write port with
// active-low write enable qualified by chip enable; cleared on reset.
module rv_rf #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_chip_en,
    input  logic            i_write_en_n,
    input  logic [4:0]      i_wr_addr,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic [4:0]      i_rd_addr1,
    input  logic [4:0]      i_rd_addr2,
    output logic [XLEN-1:0] o_rd_data1,
    output logic [XLEN-1:0] o_rd_data2
);

    logic [XLEN-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_chip_en && !i_write_en_n) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data1 = i_chip_en ? r_mem[i_rd_addr1] : '0;
    assign o_rd_data2 = i_chip_en ? r_mem[i_rd_addr2] : '0;

endmodule

// File: rtl/rv_multicycle_core.sv
// Multicycle RV32-subset core: FETCH/DECODE/EXEC/[MEM]/WB controller around RF and ALU.
// Define RV_MC_LOADSTORE_EN to build LW/SW support; otherwise those opcodes halt the core.
module rv_multicycle_core
    import rv_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned RF_DEPTH = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [XLEN-1:0]   mem_data_in,
    input  logic [XLEN-1:0]   mem_data_out,
    input  logic              mem_ready,
    output logic              retire,
    output logic              halted,
    output logic [ADDR_W+1:0] pc_out
);

    localparam int unsigned PCW = ADDR_W + 2;

    state_t          r_state, w_next;
    logic [PCW-1:0]  r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_rs1_val, r_rs2_val, r_imm, r_result;
    logic [XLEN-1:0] w_rs1_data, w_rs2_data, w_imm, w_alu_b, w_alu_y, w_wb_data;
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic [2:0]      w_func3;
    logic [3:0]      w_alu_op;
    logic            w_f7b5, w_is_r, w_is_i, w_is_load, w_is_store, w_legal;
    logic            w_rf_ce, w_rf_we_n;

    assign w_opcode   = f_opcode(r_ir);
    assign w_rd       = f_rd(r_ir);
    assign w_rs1      = f_rs1(r_ir);
    assign w_rs2      = f_rs2(r_ir);
    assign w_func3    = f_func3(r_ir);
    assign w_f7b5     = f_func7b5(r_ir);
    assign w_is_r     = (w_opcode == OP_R);
    assign w_is_i     = (w_opcode == OP_I);
    assign w_is_load  = (w_opcode == OP_LOAD)  && (w_func3 == F3_WORD);
    assign w_is_store = (w_opcode == OP_STORE) && (w_func3 == F3_WORD);

`ifdef RV_MC_LOADSTORE_EN
    logic [XLEN-1:0] r_load;
    logic            w_misaligned;

    assign w_legal      = w_is_r || w_is_i || w_is_load || w_is_store;
    assign w_misaligned = (w_alu_y[1:0] != 2'b00);
    assign w_wb_data    = w_is_load ? r_load : r_result;
`else
    assign w_legal      = w_is_r || w_is_i;
    assign w_wb_data    = r_result;
`endif

    // I-type only carries the alt bit for SRAI; loads/stores always add
    always_comb begin
        w_alu_op = ALU_ADD;
        if (w_is_r) begin
            w_alu_op = {w_func3, w_f7b5};
        end else if (w_is_i) begin
            w_alu_op = {w_func3, (w_func3 == F3_SRX) ? w_f7b5 : 1'b0};
        end
    end

    assign w_alu_b   = w_is_r ? r_rs2_val : r_imm;
    assign w_rf_ce   = (r_state == DECODE) || (r_state == WB);
    assign w_rf_we_n = !((r_state == WB) && !w_is_store && (w_rd != 5'd0));

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_imm_hi   (r_ir[31:20]),
        .i_s_lo     (r_ir[11:7]),
        .i_is_store (w_is_store),
        .o_imm      (w_imm)
    );

    rv_rf #(.XLEN(XLEN), .DEPTH(RF_DEPTH)) u_rf (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_chip_en    (w_rf_ce),
        .i_write_en_n (w_rf_we_n),
        .i_wr_addr    (w_rd),
        .i_wr_data    (w_wb_data),
        .i_rd_addr1   (w_rs1),
        .i_rd_addr2   (w_rs2),
        .o_rd_data1   (w_rs1_data),
        .o_rd_data2   (w_rs2_data)
    );

    rv_alu #(.XLEN(XLEN)) u_alu (
        .i_op (w_alu_op),
        .i_a  (r_rs1_val),
        .i_b  (w_alu_b),
        .o_y  (w_alu_y)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FETCH:   if (mem_ready) w_next = DECODE;
            DECODE:  w_next = w_legal ? EXEC : HALT;
`ifdef RV_MC_LOADSTORE_EN
            EXEC:    if (w_is_load || w_is_store) w_next = w_misaligned ? HALT : MEM;
                     else                         w_next = WB;
            MEM:     if (mem_ready) w_next = WB;
`else
            EXEC:    w_next = WB;
`endif
            WB:      w_next = FETCH;
            default: w_next = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_pc      <= PCW'(RESET_PC);
            r_ir      <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_imm     <= '0;
            r_result  <= '0;
`ifdef RV_MC_LOADSTORE_EN
            r_load    <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == FETCH && mem_ready) r_ir <= mem_data_out[31:0];
            if (r_state == DECODE) begin
                r_rs1_val <= w_rs1_data;
                r_rs2_val <= w_rs2_data;
                r_imm     <= w_imm;
            end
            if (r_state == EXEC) r_result <= w_alu_y;
`ifdef RV_MC_LOADSTORE_EN
            if (r_state == MEM && mem_ready && w_is_load) r_load <= mem_data_out;
`endif
            if (r_state == WB) r_pc <= r_pc + PCW'(4);
        end
    end

    // Requests are gated by rst_n so an asserted reset drops them in the same cycle
`ifdef RV_MC_LOADSTORE_EN
    assign mem_read_en  = rst_n && ((r_state == FETCH) || ((r_state == MEM) && w_is_load));
    assign mem_write_en = rst_n && (r_state == MEM) && w_is_store;
`else
    assign mem_read_en  = rst_n && (r_state == FETCH);
    assign mem_write_en = 1'b0;
`endif
    assign mem_addr    = (r_state == FETCH) ? r_pc[PCW-1:2] : r_result[PCW-1:2];
    assign mem_data_in = r_rs2_val;
    assign retire      = (r_state == WB);
    assign halted      = (r_state == HALT);
    assign pc_out      = r_pc;

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Directed bench for rv_multicycle_core with a behavioural wait-state memory.
module tb_rv_multicycle_core;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned WORDS  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read_en, mem_write_en, mem_ready;
    logic [XLEN-1:0]   mem_data_in, mem_data_out;
    logic              retire, halted;
    logic [ADDR_W+1:0] pc_out;

    rv_multicycle_core #(
        .XLEN     (XLEN),
        .ADDR_W   (ADDR_W),
        .RF_DEPTH (32),
        .RESET_PC (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr     (mem_addr),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_ready    (mem_ready),
        .retire       (retire),
        .halted       (halted),
        .pc_out       (pc_out)
    );

    always #5 clk = ~clk;

    logic [31:0]  prog [WORDS];
    logic [31:0]  mem  [WORDS];
    int unsigned  stall_cfg = 0;
    int unsigned  wcnt = 0;
    int unsigned  cyc = 0;
    int unsigned  retire_cnt = 0;
    int unsigned  retire_cyc [$];
    int unsigned  bad_req = 0;
    int unsigned  vec_cnt = 0;
    int unsigned  err_cnt = 0;

    assign mem_data_out = mem[mem_addr];
    assign mem_ready    = (mem_read_en || mem_write_en) && (wcnt >= stall_cfg);

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= prog[i];
        end else if (mem_write_en && mem_ready) begin
            mem[mem_addr] <= mem_data_in;
        end
    end

    always @(posedge clk) begin
        if (!rst_n || !(mem_read_en || mem_write_en) || mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // cycle numbers are 1-based from reset release
    always @(negedge clk) begin
        if (!rst_n) begin
            retire_cnt <= 0;
            bad_req    <= 0;
            retire_cyc.delete();
        end else begin
            if (retire) begin
                retire_cnt <= retire_cnt + 1;
                retire_cyc.push_back(cyc + 1);
            end
            if ((halted && (mem_read_en || mem_write_en)) || (mem_read_en && mem_write_en))
                bad_req <= bad_req + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        vec_cnt++;
        if (obs !== expd) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, expd);
        end
    endtask

    function automatic logic [31:0] xreg(input int idx);
        return dut.u_rf.r_mem[idx];
    endfunction

    task automatic load_prog(input logic [31:0] fill);
        for (int i = 0; i < WORDS; i++) prog[i] = fill;
    endtask

    task automatic hold_reset(input int unsigned stall);
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        stall_cfg = stall;
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic run_until(input string tag, input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (retire_cnt < n && !halted && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_eq(tag, retire_cnt, n);
    endtask

    task automatic wait_halt(input string tag, input int unsigned budget);
        int unsigned k = 0;
        while (!halted && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_eq(tag, {31'd0, halted}, 32'd1);
    endtask

    task automatic load_prog_a();
        load_prog(32'h0);
        prog[0]  = 32'h00500093;  // ADDI x1,x0,5
        prog[1]  = 32'h00700113;  // ADDI x2,x0,7
        prog[2]  = 32'h002081B3;  // ADD  x3,x1,x2
        prog[3]  = 32'h00900013;  // ADDI x0,x0,9
        prog[4]  = 32'hFFF00293;  // ADDI x5,x0,-1
        prog[5]  = 32'h40110233;  // SUB  x4,x2,x1
        prog[6]  = 32'hFF000393;  // ADDI x7,x0,-16
        prog[7]  = 32'h4023D413;  // SRAI x8,x7,2
        prog[8]  = 32'h0013A4B3;  // SLT  x9,x7,x1
        prog[9]  = 32'h0F02F513;  // ANDI x10,x5,0xF0
        prog[10] = 32'h0020C5B3;  // XOR  x11,x1,x2
        prog[11] = 32'h00309613;  // SLLI x12,x1,3
        prog[12] = 32'h0000007F;  // illegal
    endtask

    initial begin
        // ALU program, zero wait states, reset state
        load_prog_a();
        hold_reset(0);
        check_eq("rst_pc",     {20'd0, pc_out}, 32'd0);
        check_eq("rst_rd_en",  {31'd0, mem_read_en}, 32'd0);
        check_eq("rst_wr_en",  {31'd0, mem_write_en}, 32'd0);
        check_eq("rst_retire", {31'd0, retire}, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_addr",   {22'd0, mem_addr}, 32'd0);
        rst_n = 1'b1;
        run_until("alu_retires", 12, 100);
        check_eq("lat_first", retire_cyc[0], 32'd4);
        check_eq("lat_add",   retire_cyc[2], 32'd12);
        wait_halt("illegal_halt", 20);
        check_eq("x0",  xreg(0),  32'h0);
        check_eq("x1",  xreg(1),  32'd5);
        check_eq("x3",  xreg(3),  32'd12);
        check_eq("x4",  xreg(4),  32'd2);
        check_eq("x5",  xreg(5),  32'hFFFFFFFF);
        check_eq("x8",  xreg(8),  32'hFFFFFFFC);
        check_eq("x9",  xreg(9),  32'd1);
        check_eq("x10", xreg(10), 32'h000000F0);
        check_eq("x11", xreg(11), 32'd2);
        check_eq("x12", xreg(12), 32'd40);
        check_eq("halt_pc", {20'd0, pc_out}, 32'd48);
        repeat (5) @(negedge clk);
        #1;
        check_eq("halt_pc_frozen", {20'd0, pc_out}, 32'd48);
        check_eq("halt_no_retire", retire_cnt, 32'd12);
        check_eq("halt_no_req",    bad_req, 32'd0);

        // three fetch wait states, then reset during a fetch wait
        hold_reset(3);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check_eq("wait_rd_en", {31'd0, mem_read_en}, 32'd1);
            check_eq("wait_addr",  {22'd0, mem_addr}, 32'd0);
        end
        run_until("wait_retire2", 2, 50);
        check_eq("wait_lat1", retire_cyc[0], 32'd7);
        check_eq("wait_lat2", retire_cyc[1], 32'd14);
        @(negedge clk);
        #1;
        check_eq("pre_rst_pc", {20'd0, pc_out}, 32'd8);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_rd_en", {31'd0, mem_read_en}, 32'd0);
        check_eq("abort_pc",    {20'd0, pc_out}, 32'd0);
        check_eq("abort_rf",    xreg(1), 32'd0);
        hold_reset(0);
        rst_n = 1'b1;
        run_until("refetch", 1, 20);
        check_eq("refetch_lat", retire_cyc[0], 32'd4);
        @(negedge clk);
        #1;
        check_eq("refetch_x1", xreg(1), 32'd5);

        // misaligned / unsupported LW halts without retiring
        load_prog(32'h0);
        prog[0] = 32'h00102083;  // LW x1,1(x0)
        hold_reset(0);
        rst_n = 1'b1;
        wait_halt("lw_halt", 20);
        repeat (5) @(negedge clk);
        #1;
        check_eq("lw_halt_pc",     {20'd0, pc_out}, 32'd0);
        check_eq("lw_halt_retire", retire_cnt, 32'd0);
        check_eq("lw_halt_no_req", bad_req, 32'd0);

        // store then load of the same word
        load_prog(32'h0);
        prog[0] = 32'hFFF00293;  // ADDI x5,x0,-1
        prog[1] = 32'h04502023;  // SW x5,64(x0)
        prog[2] = 32'h04002303;  // LW x6,64(x0)
        hold_reset(0);
        rst_n = 1'b1;
`ifdef RV_MC_LOADSTORE_EN
        run_until("ls_retires", 3, 40);
        check_eq("ls_lat_sw", retire_cyc[1], 32'd9);
        check_eq("ls_lat_lw", retire_cyc[2], 32'd14);
        wait_halt("ls_halt", 20);
        check_eq("ls_mem16", mem[16], 32'hFFFFFFFF);
        check_eq("ls_x6",    xreg(6), 32'hFFFFFFFF);
        check_eq("ls_pc",    {20'd0, pc_out}, 32'd12);
`else
        wait_halt("sw_illegal_halt", 20);
        check_eq("sw_illegal_pc",     {20'd0, pc_out}, 32'd4);
        check_eq("sw_illegal_retire", retire_cnt, 32'd1);
        check_eq("sw_illegal_mem16",  mem[16], 32'h0);
`endif
        check_eq("ls_no_bad_req", bad_req, 32'd0);

        // PC wraps from the last word back to 0
        load_prog(32'h00108093);  // ADDI x1,x1,1 everywhere
        hold_reset(0);
        rst_n = 1'b1;
        run_until("wrap_1024", 1024, 4200);
        @(negedge clk);
        #1;
        check_eq("wrap_pc0", {20'd0, pc_out}, 32'd0);
        check_eq("wrap_x1",  xreg(1), 32'd1024);
        run_until("wrap_1025", 1025, 10);
        @(negedge clk);
        #1;
        check_eq("wrap_pc4",    {20'd0, pc_out}, 32'd4);
        check_eq("wrap_x1b",    xreg(1), 32'd1025);
        check_eq("wrap_halted", {31'd0, halted}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
